// File: rtl/ex.sv
// Execute stage: ALU, HI/LO registers and a 32-step restoring divider.
// Results are registered onto ex_we/ex_waddr/ex_wdata; stall_req_o holds upstream during divides.
//
// state  | meaning
// S_IDLE | accepts any op; divide with nonzero divisor latches operands
// S_BUSY | one shift-subtract step per cycle, r_cnt 0..31
// S_DONE | sign fix-up and HI/LO write, then back to idle
module ex (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  alusel_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_data_i,
  input  logic [31:0] reg2_data_i,
  input  logic        wreg_i,
  input  logic [4:0]  waddr_i,
  output logic        ex_we,
  output logic [4:0]  ex_waddr,
  output logic [31:0] ex_wdata,
  output logic        stall_req_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] SEL_LOGIC = 3'b000;
  localparam logic [2:0] SEL_SHIFT = 3'b001;
  localparam logic [2:0] SEL_ARITH = 3'b010;
  localparam logic [2:0] SEL_DIV   = 3'b011;
  localparam logic [2:0] SEL_MOVE  = 3'b100;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_is_div;
  logic        w_signed;
  logic        w_div_zero;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [31:0] w_res;
  logic        w_valid;

  assign w_is_div   = (alusel_i == SEL_DIV) && ((aluop_i == 8'h1A) || (aluop_i == 8'h1B));
  assign w_signed   = (aluop_i == 8'h1A);
  assign w_div_zero = (reg2_data_i == 32'd0);
  assign w_a_abs    = (w_signed && reg1_data_i[31]) ? (32'd0 - reg1_data_i) : reg1_data_i;
  assign w_b_abs    = (w_signed && reg2_data_i[31]) ? (32'd0 - reg2_data_i) : reg2_data_i;

  // Partial remainder stays below the divisor, so bit 32 of the difference is the borrow.
  assign w_rem_sh = {r_rem, r_quot[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_divisor};
  assign w_q_fix  = r_neg_q ? (32'd0 - r_quot) : r_quot;
  assign w_r_fix  = r_neg_r ? (32'd0 - r_rem) : r_rem;

  always_comb begin
    stall_req_o = 1'b0;
    case (r_state)
      S_IDLE:  stall_req_o = w_is_div && !w_div_zero;
      S_BUSY:  stall_req_o = 1'b1;
      default: stall_req_o = 1'b0;
    endcase
  end

  always_comb begin
    w_res   = 32'd0;
    w_valid = 1'b1;
    case (alusel_i)
      SEL_LOGIC:
        case (aluop_i)
          8'h24:        w_res = reg1_data_i & reg2_data_i;
          8'h25, 8'h0D: w_res = reg1_data_i | reg2_data_i;
          8'h26:        w_res = reg1_data_i ^ reg2_data_i;
          8'h27:        w_res = ~(reg1_data_i | reg2_data_i);
          default:      w_valid = 1'b0;
        endcase
      SEL_SHIFT:
        case (aluop_i)
          8'h00:   w_res = reg2_data_i << reg1_data_i[4:0];
          8'h02:   w_res = reg2_data_i >> reg1_data_i[4:0];
          8'h03:   w_res = $signed(reg2_data_i) >>> reg1_data_i[4:0];
          default: w_valid = 1'b0;
        endcase
      SEL_ARITH:
        case (aluop_i)
          8'h21:   w_res = reg1_data_i + reg2_data_i;
          8'h23:   w_res = reg1_data_i - reg2_data_i;
          8'h2A:   w_res = {31'd0, ($signed(reg1_data_i) < $signed(reg2_data_i))};
          8'h2B:   w_res = {31'd0, (reg1_data_i < reg2_data_i)};
          default: w_valid = 1'b0;
        endcase
      SEL_MOVE:
        case (aluop_i)
          8'h10:   w_res = r_hi;
          8'h12:   w_res = r_lo;
          default: w_valid = 1'b0;
        endcase
      default: w_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_quot    <= 32'd0;
      r_rem     <= 32'd0;
      r_divisor <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      ex_we     <= 1'b0;
      ex_waddr  <= 5'd0;
      ex_wdata  <= 32'd0;
    end else begin
      ex_we    <= 1'b0;
      ex_waddr <= 5'd0;
      ex_wdata <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (w_is_div) begin
            if (w_div_zero) begin
              r_lo <= 32'hFFFF_FFFF;
              r_hi <= reg1_data_i;
            end else begin
              r_quot    <= w_a_abs;
              r_rem     <= 32'd0;
              r_divisor <= w_b_abs;
              r_neg_q   <= w_signed && (reg1_data_i[31] ^ reg2_data_i[31]);
              r_neg_r   <= w_signed && reg1_data_i[31];
              r_cnt     <= 5'd0;
              r_state   <= S_BUSY;
            end
          end else if (w_valid) begin
            ex_we    <= wreg_i;
            ex_waddr <= waddr_i;
            ex_wdata <= w_res;
          end
        end
        S_BUSY: begin
          if (!w_diff[32]) begin
            r_rem  <= w_diff[31:0];
            r_quot <= {r_quot[30:0], 1'b1};
          end else begin
            r_rem  <= w_rem_sh[31:0];
            r_quot <= {r_quot[30:0], 1'b0};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_DONE;
        end
        S_DONE: begin
          r_hi    <= w_r_fix;
          r_lo    <= w_q_fix;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for ex: behavioural model (plain arithmetic, cycle countdown for divides)
// compared every cycle, plus literal expectations from hand-worked cases.
module tb_ex;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  alusel_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_data_i;
  logic [31:0] reg2_data_i;
  logic        wreg_i;
  logic [4:0]  waddr_i;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        stall_req_o;

  always #5 clk = ~clk;

  ex dut (
    .clk(clk), .reset_n(reset_n), .alusel_i(alusel_i), .aluop_i(aluop_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .wreg_i(wreg_i),
    .waddr_i(waddr_i), .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .stall_req_o(stall_req_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_rem = 0;
  bit          m_done = 0;
  bit          m_valid = 0;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  function automatic bit f_is_div(input logic [2:0] s, input logic [7:0] o);
    return (s == 3'b011) && (o == 8'h1A || o == 8'h1B);
  endfunction

  function automatic bit f_calc(input logic [2:0] s, input logic [7:0] o,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo,
                                output logic [31:0] r);
    r = 32'd0;
    f_calc = 1'b1;
    case ({s, o})
      {3'b000, 8'h24}: r = a & b;
      {3'b000, 8'h25}: r = a | b;
      {3'b000, 8'h0D}: r = a | b;
      {3'b000, 8'h26}: r = a ^ b;
      {3'b000, 8'h27}: r = ~(a | b);
      {3'b001, 8'h00}: r = b << a[4:0];
      {3'b001, 8'h02}: r = b >> a[4:0];
      {3'b001, 8'h03}: r = 32'($signed(b) >>> a[4:0]);
      {3'b010, 8'h21}: r = a + b;
      {3'b010, 8'h23}: r = a - b;
      {3'b010, 8'h2A}: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      {3'b010, 8'h2B}: r = (a < b) ? 32'd1 : 32'd0;
      {3'b100, 8'h10}: r = hi;
      {3'b100, 8'h12}: r = lo;
      default:         f_calc = 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] r;
    longint sa, sb, q, rm;
    if (!reset_n) begin
      m_valid = 1; m_rem = 0; m_done = 0;
      m_hi = 0; m_lo = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
    end else if (m_valid) begin
      m_we = 0; m_waddr = 0; m_wdata = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end else if (m_done) begin
        m_hi = m_phi; m_lo = m_plo; m_done = 0;
      end else if (f_is_div(alusel_i, aluop_i)) begin
        if (reg2_data_i == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = reg1_data_i;
        end else begin
          if (aluop_i == 8'h1A) begin
            sa = longint'($signed(reg1_data_i));
            sb = longint'($signed(reg2_data_i));
          end else begin
            sa = {32'd0, reg1_data_i};
            sb = {32'd0, reg2_data_i};
          end
          q = sa / sb;
          rm = sa % sb;
          m_plo = q[31:0];
          m_phi = rm[31:0];
          m_rem = 32;
        end
      end else if (f_calc(alusel_i, aluop_i, reg1_data_i, reg2_data_i, m_hi, m_lo, r)) begin
        m_we = wreg_i; m_waddr = waddr_i; m_wdata = r;
      end
    end
  end

  // One compare process, every cycle once the model has seen reset.
  always @(negedge clk) begin
    logic exp_stall;
    if (m_valid) begin
      if (m_rem > 0)   exp_stall = 1'b1;
      else if (m_done) exp_stall = 1'b0;
      else             exp_stall = f_is_div(alusel_i, aluop_i) && (reg2_data_i != 0);
      chk("cyc_we", {31'd0, ex_we}, {31'd0, m_we});
      chk("cyc_waddr", {27'd0, ex_waddr}, {27'd0, m_waddr});
      chk("cyc_wdata", ex_wdata, m_wdata);
      chk("cyc_stall", {31'd0, stall_req_o}, {31'd0, exp_stall});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] s, input logic [7:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic w, input logic [4:0] d);
    alusel_i = s; aluop_i = o; reg1_data_i = a; reg2_data_i = b; wreg_i = w; waddr_i = d;
  endtask

  // Present an instruction and hold it while stall is requested; returns after the consuming edge.
  task automatic issue(input logic [2:0] s, input logic [7:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic w, input logic [4:0] d, output int nst);
    logic st;
    drive(s, o, a, b, w, d);
    nst = 0;
    forever begin
      @(negedge clk);
      st = stall_req_o;
      @(posedge clk);
      #1;
      if (st !== 1'b1) break;
      nst++;
      if (nst > 40) begin
        checks++; errors++;
        $display("FAIL stall_timeout actual %0d required <=33", nst);
        break;
      end
    end
  endtask

  logic [10:0] op_tab [0:18] = '{
    {3'b000, 8'h24}, {3'b000, 8'h25}, {3'b000, 8'h0D}, {3'b000, 8'h26}, {3'b000, 8'h27},
    {3'b001, 8'h00}, {3'b001, 8'h02}, {3'b001, 8'h03},
    {3'b010, 8'h21}, {3'b010, 8'h23}, {3'b010, 8'h2A}, {3'b010, 8'h2B},
    {3'b100, 8'h10}, {3'b100, 8'h12}, {3'b011, 8'h1A}, {3'b011, 8'h1B},
    {3'b000, 8'hFF}, {3'b101, 8'h00}, {3'b011, 8'h1C}
  };

  initial begin
    int n;
    logic [10:0] e;
    logic [31:0] a, b;
    reset_n = 1'b0;
    drive(3'b111, 8'h00, 32'd0, 32'd0, 1'b0, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("rst_we", {31'd0, ex_we}, 32'd0);
    chk("rst_waddr", {27'd0, ex_waddr}, 32'd0);
    chk("rst_wdata", ex_wdata, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);

    issue(3'b000, 8'h0D, 32'h1234_0000, 32'h0000_5678, 1'b1, 5'd3, n);
    chk("ori_we", {31'd0, ex_we}, 32'd1);
    chk("ori_waddr", {27'd0, ex_waddr}, 32'd3);
    chk("ori_wdata", ex_wdata, 32'h1234_5678);
    issue(3'b001, 8'h03, 32'd4, 32'h8000_0000, 1'b1, 5'd4, n);
    chk("sra", ex_wdata, 32'hF800_0000);
    issue(3'b010, 8'h2A, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd5, n);
    chk("slt", ex_wdata, 32'd1);
    issue(3'b010, 8'h2B, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd6, n);
    chk("sltu", ex_wdata, 32'd0);
    issue(3'b010, 8'h23, 32'd0, 32'd1, 1'b1, 5'd7, n);
    chk("subu", ex_wdata, 32'hFFFF_FFFF);

    issue(3'b011, 8'h1A, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd8, n);
    chk("div_stall_cycles", n, 32'd33);
    issue(3'b100, 8'h12, 32'd0, 32'd0, 1'b1, 5'd9, n);
    chk("div_lo", ex_wdata, 32'hFFFF_FFFD);
    issue(3'b100, 8'h10, 32'd0, 32'd0, 1'b1, 5'd9, n);
    chk("div_hi", ex_wdata, 32'hFFFF_FFFF);

    issue(3'b011, 8'h1B, 32'hFFFF_FFFF, 32'd16, 1'b0, 5'd0, n);
    issue(3'b100, 8'h12, 32'd0, 32'd0, 1'b1, 5'd1, n);
    chk("divu_lo", ex_wdata, 32'h0FFF_FFFF);
    issue(3'b100, 8'h10, 32'd0, 32'd0, 1'b1, 5'd1, n);
    chk("divu_hi", ex_wdata, 32'h0000_000F);

    issue(3'b011, 8'h1A, 32'h0000_0055, 32'd0, 1'b0, 5'd0, n);
    chk("div0_stall_cycles", n, 32'd0);
    issue(3'b100, 8'h10, 32'd0, 32'd0, 1'b1, 5'd2, n);
    chk("div0_hi", ex_wdata, 32'h0000_0055);
    issue(3'b100, 8'h12, 32'd0, 32'd0, 1'b1, 5'd2, n);
    chk("div0_lo", ex_wdata, 32'hFFFF_FFFF);

    issue(3'b011, 8'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd0, n);
    issue(3'b100, 8'h12, 32'd0, 32'd0, 1'b1, 5'd2, n);
    chk("minint_lo", ex_wdata, 32'h8000_0000);
    issue(3'b100, 8'h10, 32'd0, 32'd0, 1'b1, 5'd2, n);
    chk("minint_hi", ex_wdata, 32'd0);

    // Abort a divide at busy count 10 with reset.
    drive(3'b011, 8'h1B, 32'd100, 32'd7, 1'b0, 5'd0);
    for (int i = 0; i < 11; i++) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    drive(3'b111, 8'h00, 32'd0, 32'd0, 1'b0, 5'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_stall", {31'd0, stall_req_o}, 32'd0);
    chk("abort_we", {31'd0, ex_we}, 32'd0);
    chk("abort_wdata", ex_wdata, 32'd0);
    issue(3'b000, 8'h0D, 32'h1234_0000, 32'h0000_5678, 1'b1, 5'd3, n);
    chk("abort_ori", ex_wdata, 32'h1234_5678);
    issue(3'b100, 8'h10, 32'd0, 32'd0, 1'b1, 5'd4, n);
    chk("abort_hi", ex_wdata, 32'd0);
    issue(3'b100, 8'h12, 32'd0, 32'd0, 1'b1, 5'd4, n);
    chk("abort_lo", ex_wdata, 32'd0);

    for (int k = 0; k < 300; k++) begin
      e = op_tab[$urandom_range(18, 0)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(3, 0) == 0) a = $urandom_range(40, 0);
      if ($urandom_range(3, 0) == 0) b = $urandom_range(9, 0);
      issue(e[10:8], e[7:0], a, b, 1'($urandom), 5'($urandom), n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage integer pipeline, directly downstream of the decode stage. Each cycle it consumes the decoded operation (`alusel_i`, `aluop_i`), the two resolved operands and the write-back target, and registers the result onto `ex_we`/`ex_waddr`/`ex_wdata`. That output feeds both the memory stage and the decode stage's forwarding path. The block also owns the HI/LO registers and a 32-iteration signed/unsigned divider, and requests a pipeline stall while a divide is in flight.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register addresses).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `alusel_i`  in  3  operation class: 000 logic, 001 shift, 010 arith, 011 divide, 100 move-from-HI/LO.
- `aluop_i`  in  8  operation within the class (codes in Operation).
- `reg1_data_i`  in  32  operand 1 (rs, or shift amount).
- `reg2_data_i`  in  32  operand 2 (rt or zero-extended immediate).
- `wreg_i`  in  1  instruction writes a GPR.
- `waddr_i`  in  5  GPR destination.
- `ex_we`  out  1  registered GPR write enable.
- `ex_waddr`  out  5  registered GPR destination.
- `ex_wdata`  out  32  registered result.
- `stall_req_o`  out  1  combinational; freezes PC and the decode stage while high.

## Operation
- Logic (000): 8'h24 AND, 8'h25 OR, 8'h0D OR (immediate form), 8'h26 XOR, 8'h27 NOR.
- Shift (001): 8'h00 SLL, 8'h02 SRL, 8'h03 SRA.
  - Value is `reg2_data_i`; amount is `reg1_data_i[4:0]` (upper bits ignored).
- Arith (010):
  - 8'h21 ADDU and 8'h23 SUBU (`reg1` − `reg2`): wrap modulo 2^32, no overflow detection.
  - 8'h2A SLT (signed) and 8'h2B SLTU (unsigned): result is 32'd1 or 32'd0.
- Move (100): 8'h10 MFHI, 8'h12 MFLO; result is the current HI/LO.
- Divide (011): 8'h1A DIV (signed), 8'h1B DIVU. Dividend is `reg1`, divisor is `reg2`. Writes LO = quotient and HI = remainder. `ex_we` stays 0.
- Unrecognised alusel/aluop: `ex_we`=0, `ex_waddr`=0, `ex_wdata`=0 (bubble).
- Non-divide ops: `ex_we`<=`wreg_i`, `ex_waddr`<=`waddr_i`, `ex_wdata`<=result.
- Divider state machine, states IDLE, BUSY, DONE:
  - IDLE, divide op with divisor ≠ 0:
    - Latch operands. Signed mode uses absolute values and records the quotient and remainder signs.
    - Clear counter; go to BUSY.
  - IDLE, divide op with divisor = 0: completes in one cycle. LO<=32'hFFFFFFFF, HI<=dividend; stay in IDLE.
  - BUSY: one restoring shift-subtract step per cycle, counter 0..31. At count 31 go to DONE.
  - DONE:
    - Apply sign fix-up: quotient negated if the operand signs differ; remainder takes the dividend's sign.
    - Write HI/LO; go to IDLE unconditionally.
    - A divide op still visible on the inputs during DONE is not restarted.
- Signed −2^31 / −1: LO=32'h80000000, HI=0 (natural result; no special case).
- Output registers during the IDLE→BUSY edge, BUSY, and DONE: `ex_we`=0, `ex_waddr`=0, `ex_wdata`=0.

## Timing
- Reset (`reset_n` low at a rising edge): `ex_we`=0, `ex_waddr`=0, `ex_wdata`=0, HI=0, LO=0, state IDLE, counter 0, `stall_req_o`=0.
  - Reset during BUSY or DONE aborts the divide; HI/LO are cleared, not partially written.
- Non-divide latency is 1 cycle. Operands are sampled at edge N and the result is visible after edge N. Back-to-back dependent instructions forward through decode with no stall.
- `stall_req_o` is high:
  - in IDLE when a divide op with nonzero divisor is present;
  - throughout BUSY;
  - low in DONE.
  - Total: 33 stall cycles per divide; the divide occupies the stage for 34 cycles.
- Upstream holds all inputs stable while `stall_req_o`=1. The block does not re-sample operands in BUSY.
- HI/LO update at the DONE edge, so MFHI/MFLO in the very next instruction returns the new value.
- Divide by zero: no stall; HI/LO are visible to the next instruction.

## Test plan
- Reset then OR-immediate: `reg1`=32'h12340000, `reg2`=32'h00005678, alusel 000, aluop 8'h0D, `wreg_i`=1, `waddr_i`=3 -> after the edge, `ex_we`=1, `ex_waddr`=3, `ex_wdata`=32'h12345678.
- Shifts and compares:
  - SRA `reg1`=4, `reg2`=32'h80000000 -> 32'hF8000000.
  - SLT `reg1`=32'hFFFFFFFF, `reg2`=1 -> 1.
  - SLTU with the same operands -> 0.
  - SUBU 0−1 -> 32'hFFFFFFFF.
- DIV signed −7/2 (32'hFFFFFFF9, 2) -> `stall_req_o` high for exactly 33 cycles and `ex_we`=0 throughout; then MFLO -> 32'hFFFFFFFD and MFHI -> 32'hFFFFFFFF.
- DIVU 32'hFFFFFFFF/16 -> LO=32'h0FFFFFFF, HI=32'hF.
- DIV by zero, dividend 32'h00000055 -> no stall; next MFHI -> 32'h00000055, MFLO -> 32'hFFFFFFFF.
- Reset asserted at BUSY count 10 -> next cycle: state IDLE, `stall_req_o`=0, HI=LO=0, all outputs 0; a following ORI executes normally.
